fib_ram_reader: RTL

//  Read side of the Fibonacci RAM. On START it scans all 2^n RAM words in order.
//  It presents each word on DISP_VAL for the seven-segment display and checks each

---
 rtl/fib_pkg.sv | 17 +
 rtl/cntr_up_clr_nb.sv | 30 +++
 rtl/fib_ram_reader.sv | 118 +++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared constants and FSM state type for the Fibonacci RAM writer/reader pair.
package fib_pkg;

  localparam int unsigned FIB_N     = 4;
  localparam int unsigned FIB_M     = 11;
  localparam int unsigned FIB_SEED0 = 0;
  localparam int unsigned FIB_SEED1 = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_FINISH  = 3'd4
  } fib_state_e;

endpackage

// File: rtl/cntr_up_clr_nb.sv
// n-bit up counter with synchronous clear and parallel load; RCO flags the all-ones count.
module cntr_up_clr_nb #(
  parameter int unsigned n = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         UP,
  input  logic         LD,
  input  logic [n-1:0] D,
  output logic [n-1:0] COUNT,
  output logic         RCO
);

  logic [n-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      count_q <= '0;
    end else if (LD) begin
      count_q <= D;
    end else if (UP) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign COUNT = count_q;
  assign RCO   = &count_q;

endmodule

// File: rtl/fib_ram_reader.sv
// Scans the Fibonacci RAM, displays each word at TICK pace and flags the first
// address that breaks the recurrence.
module fib_ram_reader
  import fib_pkg::*;
#(
  parameter int unsigned n     = FIB_N,
  parameter int unsigned m     = FIB_M,
  parameter int unsigned SEED0 = FIB_SEED0,
  parameter int unsigned SEED1 = FIB_SEED1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         TICK,
  output logic [n-1:0] RAM_ADDR,
  input  logic [m-1:0] RAM_DATA,
  output logic [m-1:0] DISP_VAL,
  output logic [n-1:0] DISP_ADDR,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic [n-1:0] ERR_ADDR
);

  fib_state_e   state_q;
  logic [n-1:0] addr;
  logic         last;
  logic         cnt_clr, cnt_up;
  logic [m-1:0] disp_val_q, p1_q, p2_q;
  logic [n-1:0] disp_addr_q, err_addr_q;
  logic         busy_q, done_q, err_q;
  logic [m:0]   exp_sum;
  logic         mismatch;

  assign cnt_clr = (state_q == S_IDLE) && START;
  // The counter must stop on the last address, so HOLD&TICK only counts below it.
  assign cnt_up  = (state_q == S_HOLD) && TICK && !last;

  cntr_up_clr_nb #(.n(n)) u_addr_cntr (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (cnt_clr),
    .UP    (cnt_up),
    .LD    (1'b0),
    .D     ('0),
    .COUNT (addr),
    .RCO   (last)
  );

  // Sum is kept one bit wider so an m-bit overflow can never match the RAM word.
  always_comb begin
    exp_sum = {1'b0, p1_q} + {1'b0, p2_q};
    if (addr == '0) begin
      exp_sum = (m+1)'(SEED0);
    end else if (addr == n'(1)) begin
      exp_sum = (m+1)'(SEED1);
    end
    mismatch = (exp_sum != {1'b0, RAM_DATA});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      disp_val_q  <= '0;
      disp_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          disp_val_q  <= RAM_DATA;
          disp_addr_q <= addr;
          p2_q        <= p1_q;
          p1_q        <= RAM_DATA;
          if (mismatch && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= addr;
          end
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (TICK) begin
            state_q <= last ? S_FINISH : S_ISSUE;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RAM_ADDR  = addr;
  assign DISP_VAL  = disp_val_q;
  assign DISP_ADDR = disp_addr_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign ERR_ADDR  = err_addr_q;

endmodule
